// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and helpers for the chained matrix multiplier
//   bank_t        - row-store bank occupancy (EMPTY/FULL)
//   lane_lsb      - bit offset of lane n in a packed row of w-bit lanes
//   requant       - arithmetic shift then saturate or wrap to a signed dw-bit range
//   requant_ovf   - high when requant changed the shifted value
package matmul_pkg;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_t;

    function automatic int lane_lsb(input int n, input int w);
        return n * w;
    endfunction

    // Works on a 64-bit signed carrier so one function serves any DW; callers
    // keep only the low DW bits of the result.
    function automatic logic [63:0] requant(input logic signed [63:0] x, input int shift,
                                            input int dw, input logic sat);
        logic signed [63:0] s, hi, lo;
        s  = x >>> shift;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (!sat)
            return (s <<< (64 - dw)) >>> (64 - dw);
        return s > hi ? hi : (s < lo ? lo : s);
    endfunction

    function automatic logic requant_ovf(input logic signed [63:0] x, input int shift,
                                         input int dw, input logic sat);
        return requant(x, shift, dw, sat) != $unsigned(x >>> shift);
    endfunction

endpackage

// File: rtl/mac_row_lanes.sv
// mac_row_lanes: N parallel signed MACs sharing one scalar operand
//   clk, rstn - clock, asynchronous active-low reset
//   en        - accept one beat: accumulate x*v[n] into every lane
//   last      - with en, the accumulators clear instead of storing the sum
//   x         - signed scalar shared by all lanes
//   v         - packed row, lane n = v[n*IW +: IW] (signed)
//   sum       - acc+product per lane (combinational), lane n = sum[n*AW +: AW]
module mac_row_lanes
    import matmul_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = 8,
    parameter int AW = 2 * IW + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 last,
    input  logic signed [IW-1:0] x,
    input  logic [N*IW-1:0]      v,
    output logic [N*AW-1:0]      sum
);

    for (genvar n = 0; n < N; n++) begin : g_lane
        logic signed [AW-1:0]   acc;
        logic signed [2*IW-1:0] p;
        assign p = x * $signed(v[lane_lsb(n, IW) +: IW]);
        assign sum[lane_lsb(n, AW) +: AW] = acc + AW'(p);
        always_ff @(posedge clk or negedge rstn)
            if (!rstn)
                acc <= '0;
            else if (en)
                acc <= last ? '0 : acc + AW'(p);
    end

endmodule

// File: rtl/matmul_chain_db.sv
// matmul_chain_db: D = C x (A x B) with a double-buffered requantised T row store
//   clk_i, rstn_i       - clock, asynchronous active-low reset
//   en_i                - global enable; low freezes state and drops both readies
//   a_valid_i/a_ready_o - stage-1 beat handshake: scalar a_i plus B row b_i
//   c_valid_i/c_ready_o - stage-2 beat handshake: scalar c_i
//   d_valid_o/d_ready_i - output row handshake: d_o row, d_last_o on last row
//   ovf_o               - sticky flag, set when any T element saturated or wrapped
module matmul_chain_db
    import matmul_pkg::*;
#(
    parameter int N     = 8,
    parameter int DW    = 8,
    parameter int SHIFT = 0,
    parameter int SAT   = 1,
    parameter int AW    = 2 * DW + $clog2(N),
    parameter int OW    = 2 * DW + $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            en_i,
    input  logic            a_valid_i,
    output logic            a_ready_o,
    input  logic [DW-1:0]   a_i,
    input  logic [N*DW-1:0] b_i,
    input  logic            c_valid_i,
    output logic            c_ready_o,
    input  logic [DW-1:0]   c_i,
    output logic            d_valid_o,
    input  logic            d_ready_i,
    output logic [N*OW-1:0] d_o,
    output logic            d_last_o,
    output logic            ovf_o
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    bank_t           bank [2];
    logic            wr, rd;
    logic [CW-1:0]   k1, i1, k2, j2;
    logic [N*DW-1:0] t_mem [2][N];
    logic            a_fire, a_last, fill, c_fire, c_last, rel;
    logic [N*AW-1:0] sum1;
    logic [N*OW-1:0] sum2;
    logic [N*DW-1:0] t_row;
    logic [N-1:0]    t_ovf;

    // Readies are gated by reset so every output reads 0 while rstn_i is low.
    assign a_ready_o = rstn_i & en_i & (bank[wr] != FULL);
    assign c_ready_o = rstn_i & en_i & (bank[rd] == FULL) & !(d_valid_o & !d_ready_i);
    assign a_fire    = a_valid_i & a_ready_o;
    assign a_last    = a_fire & (k1 == LAST);
    assign fill      = a_last & (i1 == LAST);
    assign c_fire    = c_valid_i & c_ready_o;
    assign c_last    = c_fire & (k2 == LAST);
    assign rel       = c_last & (j2 == LAST);

    mac_row_lanes #(.N(N), .IW(DW), .AW(AW)) u_mac1 (
        .clk  (clk_i),
        .rstn (rstn_i),
        .en   (a_fire),
        .last (a_last),
        .x    (a_i),
        .v    (b_i),
        .sum  (sum1)
    );

    mac_row_lanes #(.N(N), .IW(DW), .AW(OW)) u_mac2 (
        .clk  (clk_i),
        .rstn (rstn_i),
        .en   (c_fire),
        .last (c_last),
        .x    (c_i),
        .v    (t_mem[rd][k2]),
        .sum  (sum2)
    );

    for (genvar n = 0; n < N; n++) begin : g_rq
        assign t_row[lane_lsb(n, DW) +: DW] =
            DW'(requant(64'($signed(sum1[lane_lsb(n, AW) +: AW])), SHIFT, DW, SAT != 0));
        assign t_ovf[n] =
            requant_ovf(64'($signed(sum1[lane_lsb(n, AW) +: AW])), SHIFT, DW, SAT != 0);
    end

    always_ff @(posedge clk_i)
        if (a_last)
            t_mem[wr][i1] <= t_row;

    // A fill only targets a non-FULL bank and a release only a FULL one, so
    // both may fire in the same cycle without touching the same bank.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bank[0]   <= EMPTY;
            bank[1]   <= EMPTY;
            wr        <= 1'b0;
            rd        <= 1'b0;
            k1        <= '0;
            i1        <= '0;
            k2        <= '0;
            j2        <= '0;
            d_o       <= '0;
            d_valid_o <= 1'b0;
            d_last_o  <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            if (a_fire)
                k1 <= a_last ? '0 : k1 + CW'(1);
            if (a_last) begin
                i1    <= (i1 == LAST) ? '0 : i1 + CW'(1);
                ovf_o <= ovf_o | (|t_ovf);
            end
            if (fill) begin
                bank[wr] <= FULL;
                wr       <= ~wr;
            end
            if (c_fire)
                k2 <= c_last ? '0 : k2 + CW'(1);
            if (c_last)
                j2 <= (j2 == LAST) ? '0 : j2 + CW'(1);
            if (rel) begin
                bank[rd] <= EMPTY;
                rd       <= ~rd;
            end
            // The output handshake is honoured even with en_i low.
            if (c_last) begin
                d_o       <= sum2;
                d_valid_o <= 1'b1;
                d_last_o  <= (j2 == LAST);
            end else if (d_ready_i) begin
                d_valid_o <= 1'b0;
                d_last_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matmul_chain_db.sv
// tb_matmul_chain_db: directed bench for matmul_chain_db (saturating instance
// plus a SHIFT=7 wrapping instance sharing the same input stream)
module tb_matmul_chain_db;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int OW = 2 * DW + $clog2(N);
    localparam int W  = N * OW;

    logic clk = 1'b0, rstn = 1'b0, en = 1'b1;
    logic a_valid = 1'b0, c_valid = 1'b0, d_ready = 1'b1;
    logic [DW-1:0]   a_d = '0, c_d = '0;
    logic [N*DW-1:0] b_d = '0;
    logic a_ready, c_ready, d_valid, d_last, ovf;
    logic a_ready2, c_ready2, d_valid2, d_last2, ovf2;
    logic [W-1:0] d_o, d_o2, hold;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q1 [$];
    logic [W-1:0] q2 [$];
    logic         l1 [$];
    logic         l2 [$];

    logic [DW-1:0]   am [N][N];
    logic [DW-1:0]   cm [N][N];
    logic [N*DW-1:0] bm [N];

    matmul_chain_db u_dut (
        .clk_i(clk), .rstn_i(rstn), .en_i(en),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_i(a_d), .b_i(b_d),
        .c_valid_i(c_valid), .c_ready_o(c_ready), .c_i(c_d),
        .d_valid_o(d_valid), .d_ready_i(d_ready), .d_o(d_o),
        .d_last_o(d_last), .ovf_o(ovf)
    );

    matmul_chain_db #(.SHIFT(7), .SAT(0)) u_dut2 (
        .clk_i(clk), .rstn_i(rstn), .en_i(en),
        .a_valid_i(a_valid), .a_ready_o(a_ready2), .a_i(a_d), .b_i(b_d),
        .c_valid_i(c_valid), .c_ready_o(c_ready2), .c_i(c_d),
        .d_valid_o(d_valid2), .d_ready_i(d_ready), .d_o(d_o2),
        .d_last_o(d_last2), .ovf_o(ovf2)
    );

    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so the negedge view predicts the handshake.
    always @(negedge clk) begin
        if (d_valid && d_ready) begin
            q1.push_back(d_o);
            l1.push_back(d_last);
        end
        if (d_valid2 && d_ready) begin
            q2.push_back(d_o2);
            l2.push_back(d_last2);
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
        q1.delete(); q2.delete(); l1.delete(); l2.delete();
    endtask

    task automatic beat_a(input logic [DW-1:0] av, input logic [N*DW-1:0] bv);
        int t = 0;
        a_valid = 1'b1; a_d = av; b_d = bv;
        @(negedge clk);
        while (!a_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!a_ready) chk("a_ready_timeout", W'(a_ready), W'(1));
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic beat_c(input logic [DW-1:0] cv);
        int t = 0;
        c_valid = 1'b1; c_d = cv;
        @(negedge clk);
        while (!c_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!c_ready) chk("c_ready_timeout", W'(c_ready), W'(1));
        @(posedge clk); #1;
        c_valid = 1'b0;
    endtask

    task automatic send_a(input int lo, input int hi);
        for (int b = lo; b < hi; b++) beat_a(am[b / N][b % N], bm[b % N]);
    endtask

    task automatic send_c(input int lo, input int hi);
        for (int b = lo; b < hi; b++) beat_c(cm[b / N][b % N]);
    endtask

    task automatic set_a(input int diag, input int fill);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) am[i][k] = DW'(i == k ? diag : fill);
    endtask

    task automatic set_c(input int diag, input int fill);
        for (int j = 0; j < N; j++)
            for (int k = 0; k < N; k++) cm[j][k] = DW'(j == k ? diag : fill);
    endtask

    task automatic set_b(input bit kn, input int cst);
        for (int k = 0; k < N; k++)
            for (int n = 0; n < N; n++) bm[k][n*DW +: DW] = DW'(kn ? k + n : cst);
    endtask

    // Expected d[j][n] = m*(j+n) + c, rows in order, d_last only on row N-1.
    task automatic check_mat(input bit sel, input string tag, input int m, input int c);
        logic [W-1:0] e, row;
        logic         lst;
        chk({tag, "_rows"}, W'(sel ? q2.size() : q1.size()), W'(N));
        for (int j = 0; j < N; j++) begin
            if ((sel ? q2.size() : q1.size()) == 0) break;
            for (int n = 0; n < N; n++) e[n*OW +: OW] = OW'(m * (j + n) + c);
            row = sel ? q2.pop_front() : q1.pop_front();
            lst = sel ? l2.pop_front() : l1.pop_front();
            chk($sformatf("%s_row%0d", tag, j), row, e);
            chk($sformatf("%s_last%0d", tag, j), W'(lst), W'(j == N - 1));
        end
    endtask

    initial begin
        logic [W-1:0] e0;
        // reset state
        @(negedge clk);
        chk("rst_a_ready", W'(a_ready), W'(0));
        chk("rst_c_ready", W'(c_ready), W'(0));
        chk("rst_d_valid", W'(d_valid), W'(0));
        chk("rst_d_o", d_o, W'(0));
        chk("rst_d_last", W'(d_last), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_a_ready", W'(a_ready), W'(1));
        chk("post_rst_c_ready", W'(c_ready), W'(0));
        @(posedge clk); #1;

        // identity chain
        set_a(1, 0); set_b(1, 0); set_c(1, 0);
        send_a(0, 64);
        chk("t1_c_ready", W'(c_ready), W'(1));
        chk("t1_a_ready", W'(a_ready), W'(1));
        send_c(0, 64);
        cyc(3);
        check_mat(0, "t1", 1, 0);
        chk("t1_ovf", W'(ovf), W'(0));

        // positive saturation
        do_reset();
        set_a(127, 127); set_b(0, 127); set_c(1, 0);
        send_a(0, 64);
        chk("t2_ovf", W'(ovf), W'(1));
        send_c(0, 64);
        cyc(3);
        check_mat(0, "t2", 0, 127);

        // negative saturation
        do_reset();
        set_a(-128, -128);
        send_a(0, 64);
        chk("t2n_ovf", W'(ovf), W'(1));
        send_c(0, 64);
        cyc(3);
        check_mat(0, "t2n", 0, -128);

        // reset mid-matrix, ovf still set from the last run
        send_a(0, 30);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ovf", W'(ovf), W'(0));
        chk("mid_rst_a_ready", W'(a_ready), W'(0));
        chk("mid_rst_d_valid", W'(d_valid), W'(0));
        chk("mid_rst_d_o", d_o, W'(0));
        cyc(2);
        rstn = 1'b1;
        q1.delete(); q2.delete(); l1.delete(); l2.delete();
        @(negedge clk);
        chk("mid_rst_rel_a_ready", W'(a_ready), W'(1));
        @(posedge clk); #1;

        // fresh identity run with an enable stall mid-matrix
        set_a(1, 0); set_b(1, 0); set_c(1, 0);
        send_a(0, 20);
        en = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk($sformatf("en_stall_a_ready%0d", s), W'(a_ready), W'(0));
        end
        @(posedge clk); #1;
        en = 1'b1;
        send_a(20, 64);
        send_c(0, 64);
        cyc(3);
        check_mat(0, "t6", 1, 0);
        chk("t6_ovf", W'(ovf), W'(0));

        // SHIFT=7 wrap instance: 2048>>>7 = 16; saturating instance clamps to 127
        do_reset();
        set_a(16, 16); set_b(0, 16); set_c(1, 1);
        send_a(0, 64);
        chk("t3_ovf2", W'(ovf2), W'(0));
        chk("t3_ovf", W'(ovf), W'(1));
        send_c(0, 64);
        cyc(3);
        check_mat(1, "t3w", 0, 128);
        check_mat(0, "t3s", 0, 1016);

        // output backpressure
        do_reset();
        set_a(1, 0); set_b(1, 0); set_c(1, 0);
        send_a(0, 64);
        d_ready = 1'b0;
        send_c(0, 8);
        chk("bp_d_valid0", W'(d_valid), W'(1));
        hold = d_o;
        for (int n = 0; n < N; n++) e0[n*OW +: OW] = OW'(n);
        chk("bp_row0", hold, e0);
        repeat (20) @(negedge clk);
        chk("bp_d_stable", d_o, hold);
        chk("bp_d_valid", W'(d_valid), W'(1));
        chk("bp_c_ready", W'(c_ready), W'(0));
        @(posedge clk); #1;
        d_ready = 1'b1;
        send_c(8, 64);
        cyc(3);
        check_mat(0, "bp", 1, 0);

        // two matrices back-to-back, both banks full
        do_reset();
        set_a(1, 0); set_b(1, 0); set_c(1, 0);
        send_a(0, 64);
        set_a(2, 0);
        send_a(0, 64);
        @(negedge clk);
        chk("b2b_full_a_ready", W'(a_ready), W'(0));
        @(posedge clk); #1;
        send_c(0, 63);
        chk("b2b_pre_rel_a_ready", W'(a_ready), W'(0));
        send_c(63, 64);
        chk("b2b_rel_a_ready", W'(a_ready), W'(1));
        cyc(3);
        check_mat(0, "b2b1", 1, 0);
        send_c(0, 64);
        cyc(3);
        check_mat(0, "b2b2", 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_chain_db.md
Name: matmul_chain_db

Overview:
- Parametrised two-stage chained matrix multiplier: D = C × (A × B); all matrices are N×N signed.
- Stage 1 streams one scalar a[i][k] plus one B row b[k][*] per beat, accumulates, then requantises each row of T = A×B into a double-buffered row store.
- Stage 2 streams one scalar c[j][k] per beat against stored T row k and emits each D row on a valid/ready output.
- Successor of the fixed 8-lane matmul/storage/matmul chain; adds width/lane parameters, backpressure, double buffering, requantisation and saturation.

Parameters:
- N, 8, lanes and matrix dimension (≥2).
- DW, 8, input and stored-T element width (signed).
- SHIFT, 0, arithmetic right shift applied to stage-1 sums before storage.
- SAT, 1, 1 = saturate T to signed DW; 0 = wrap (keep low DW bits).
- AW, 2*DW+$clog2(N), stage-1 accumulator width (derived).
- OW, 2*DW+$clog2(N), output element width (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- en_i  in  1  global enable; low = freeze all state, both readies low.
- a_valid_i  in  1  stage-1 beat valid.
- a_ready_o  out  1  stage-1 beat accepted when valid&ready.
- a_i  in  DW  scalar a[i][k].
- b_i  in  N*DW  row b[k][*]; lane n = bits [n*DW +: DW].
- c_valid_i  in  1  stage-2 beat valid.
- c_ready_o  out  1  stage-2 beat accepted when valid&ready.
- c_i  in  DW  scalar c[j][k].
- d_valid_o  out  1  output row valid.
- d_ready_i  in  1  output row consumed when valid&ready.
- d_o  out  N*OW  row d[j][*]; lane n = bits [n*OW +: OW].
- d_last_o  out  1  marks row j = N-1.
- ovf_o  out  1  sticky: any T element saturated or wrapped.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; counters 0; both banks EMPTY; write/read bank pointers 0; accumulators 0.
- Beat order, stage 1: k increments fastest (0..N-1), then row i (0..N-1). Same order for stage 2 with j in place of i.
- Stage 1, per accepted beat: acc[n] += a_i*b_i[n], signed, AW bits.
- Stage 1, on k = N-1 beat: final sum (acc+product) is shifted >>>SHIFT, then clamped to [-2^(DW-1), 2^(DW-1)-1] (SAT=1) or truncated (SAT=0). Result is written to bank[wr] row i at that edge; acc cleared; ovf_o set if clamp or wrap changed any value.
- Stage 1, on i = N-1 beat: bank[wr] becomes FULL and wr toggles at that edge.
- a_ready_o = en_i & bank[wr] not FULL.
- c_ready_o = en_i & bank[rd] FULL & !(d_valid_o & !d_ready_i).
- Stage 2, per accepted beat: acc2[n] += c_i*T[k][n], OW bits.
- Stage 2, on k = N-1 beat: the final sum loads d_o and d_valid_o = 1 at that edge (one-cycle latency from last beat); d_last_o = (j = N-1); acc2 cleared.
- Stage 2, on j = N-1, k = N-1 beat: bank[rd] becomes EMPTY and rd toggles.
- d_valid_o clears on handshake unless a new row loads in the same cycle. d_o is held stable while d_valid_o=1 & d_ready_i=0.
- Simultaneous events: stage-1 fill and stage-2 release of different banks in one cycle both take effect. A bank released this cycle is writable next cycle; a bank filled this cycle is readable next cycle.
- Both banks FULL: a_ready_o low until stage 2 releases one.
- en_i low mid-matrix: counters, accumulators and outputs hold; no beat is accepted. d_valid_o stays asserted; a d handshake is still honoured.
- Reset mid-operation: partial matrices are discarded; ovf_o cleared.

Decomposition:
- Package matmul_pkg: lane pack/unpack helpers, saturate/requantise function, bank-state encoding (EMPTY/FULL).
- Sub-module mac_row_lanes (N parallel signed MACs with clear-on-last and accumulator-width parameter), instantiated twice: AW for stage 1, OW for stage 2.
- Bank store, counters and handshake logic live in the top.

Test Plan:
- A=I, b[k][n]=k+n, C=I, SHIFT=0 -> d[j][n]=j+n for all j,n; d_last_o on row 7 only; ovf_o=0.
- A all 127, B all 127, SAT=1 -> T=127 (sum 129032 clamped), ovf_o=1; C=I -> every d element 127. Repeat with A=-128, B=127 -> T=-128, D=-128.
- SAT=0, SHIFT=7, A=B all 16 -> sum 2048>>>7 = 16, no overflow; C all 1 -> d elements 128.
- d_ready_i held low 20 cycles after first D row -> d_o stable, c_ready_o low, d_valid_o high; after release all 8 rows arrive in order with correct values.
- Two A/B matrices streamed back-to-back, no C traffic -> a_ready_o low after beat 128; first full C matrix (64 beats) -> a_ready_o high the cycle after the final C beat; second D equals the second product.
- rstn_i asserted after 30 A beats -> all outputs 0 immediately; after release a_ready_o=1 and a fresh identity test passes. Also: en_i low for 5 cycles mid-matrix -> result unchanged versus the no-stall run.
